// File: rtl/rhs_spi_pkg.sv
// Shared definitions for the RHS2116 SPI responder: command opcodes, response tags,
// identity ROM contents and the frame FSM encoding.
package rhs_spi_pkg;

  localparam int WORD_BITS = 32;

  localparam logic [1:0]  CMD_CONVERT    = 2'b00;
  localparam logic [1:0]  CMD_WRITE      = 2'b10;
  localparam logic [1:0]  CMD_READ       = 2'b11;
  localparam logic [7:0]  CLEAR_BYTE     = 8'h6A;
  localparam logic [15:0] RESP_WRITE_TAG = 16'hFFFF;

  localparam logic [5:0]  BITCNT_FULL      = 6'd32;
  localparam logic [5:0]  BITCNT_SAT       = 6'd33;
  localparam logic [5:0]  CONVERT_CH_LIMIT = 6'd16;

  // Read-only identity words ("INTA ") above the writable register space
  localparam logic [7:0]  ROM_ADDR_0 = 8'd251;
  localparam logic [7:0]  ROM_ADDR_1 = 8'd252;
  localparam logic [7:0]  ROM_ADDR_2 = 8'd253;
  localparam logic [7:0]  ROM_ADDR_3 = 8'd254;
  localparam logic [7:0]  ROM_ADDR_4 = 8'd255;
  localparam logic [15:0] ROM_DATA_0 = 16'h0049;
  localparam logic [15:0] ROM_DATA_1 = 16'h004E;
  localparam logic [15:0] ROM_DATA_2 = 16'h0054;
  localparam logic [15:0] ROM_DATA_3 = 16'h0041;
  localparam logic [15:0] ROM_DATA_4 = 16'h0020;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_EXEC      = 2'd3
  } state_t;

  function automatic logic [15:0] rom_lookup(input logic [7:0] addr);
    logic [15:0] val;
    case (addr)
      ROM_ADDR_0: val = ROM_DATA_0;
      ROM_ADDR_1: val = ROM_DATA_1;
      ROM_ADDR_2: val = ROM_DATA_2;
      ROM_ADDR_3: val = ROM_DATA_3;
      ROM_ADDR_4: val = ROM_DATA_4;
      default:    val = 16'h0000;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/rhs_spi_edge_sync.sv
// Multi-stage synchronizer for one asynchronous SPI line, with single-cycle
// rise/fall pulses derived from the synchronized level.
module rhs_spi_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Synchronizer chain plus one-cycle history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign level = sync_r[STAGES-1];
  assign rise  = sync_r[STAGES-1] & ~prev_r;
  assign fall  = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/rhs_spi_responder.sv
// RHS2116 SPI responder emulator: oversampled SPI slave with a two-deep result
// pipeline, CONVERT sample synthesis, a small register file and identity ROM.
module rhs_spi_responder
  import rhs_spi_pkg::*;
#(
  parameter int STARTING_SEED = 0,
  parameter int SYNC_STAGES   = 2,
  parameter int REG_COUNT     = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SCLK,
  input  logic                 CS,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic                 cmd_valid,
  output logic [WORD_BITS-1:0] cmd_word,
  output logic [5:0]           channel_out,
  output logic                 frame_error
);

  localparam logic [15:0] SEED16    = 16'(STARTING_SEED);
  localparam logic [8:0]  REG_LIMIT = 9'(REG_COUNT);
  localparam int          AW        = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  logic sclk_unused_s, sclk_rise_s, sclk_fall_s;
  logic cs_s, cs_rise_s, cs_fall_s;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic mosi_s;

  state_t state_r, state_next_s;
  logic start_s, sample_s, advance_s, exec_s, ferr_s;

  logic [WORD_BITS-1:0] shreg_in_r, shreg_out_r, pipe0_r, pipe1_r;
  logic [WORD_BITS-1:0] cmd_word_r, result_s;
  logic [5:0]  bitcnt_r, channel_r, ch_s;
  logic [15:0] conv_count_r, conv_next_s, sample_val_s, rd_s;
  logic [15:0] regs_r [0:REG_COUNT-1];
  logic [7:0]  addr_s;
  logic        in_range_s, wr_en_s, is_convert_s;
  logic        miso_r, cmd_valid_r, frame_error_r;

  rhs_spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(SCLK),
    .level(sclk_unused_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  rhs_spi_edge_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .rst(rst), .din(CS),
    .level(cs_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  // MOSI needs only the synchronizer; it is qualified by the SCLK rise pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sync_r <= '0;
    end else begin
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
    end
  end
  assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

  // Frame FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_WAIT_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Frame FSM next state and datapath strobes
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    sample_s     = 1'b0;
    advance_s    = 1'b0;
    exec_s       = 1'b0;
    ferr_s       = 1'b0;
    case (state_r)
      ST_WAIT_IDLE: begin
        if (cs_s) state_next_s = ST_IDLE;
        else      state_next_s = ST_WAIT_IDLE;
      end
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_next_s = ST_SHIFT;
          start_s      = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cs_rise_s) begin
          if (bitcnt_r == BITCNT_FULL) begin
            state_next_s = ST_EXEC;
          end else begin
            state_next_s = ST_IDLE;
            ferr_s       = 1'b1;
          end
        end else begin
          sample_s  = sclk_rise_s;
          advance_s = sclk_fall_s;
        end
      end
      ST_EXEC: begin
        exec_s       = 1'b1;
        state_next_s = ST_IDLE;
      end
      default: state_next_s = ST_WAIT_IDLE;
    endcase
  end

  assign addr_s       = shreg_in_r[23:16];
  assign ch_s         = shreg_in_r[21:16];
  assign in_range_s   = ({1'b0, addr_s} < REG_LIMIT);
  assign sample_val_s = SEED16 + {10'd0, ch_s} + conv_count_r;

  // Command decode of the captured word
  always_comb begin
    result_s     = 32'h0000_0000;
    conv_next_s  = conv_count_r;
    wr_en_s      = 1'b0;
    is_convert_s = 1'b0;
    if (in_range_s) rd_s = regs_r[addr_s[AW-1:0]];
    else            rd_s = rom_lookup(addr_s);
    case (shreg_in_r[31:30])
      CMD_CONVERT: begin
        is_convert_s = 1'b1;
        conv_next_s  = conv_count_r + 16'd1;
        if (ch_s < CONVERT_CH_LIMIT) result_s = {16'h0000, sample_val_s};
        else                         result_s = 32'h0000_0000;
      end
      CMD_WRITE: begin
        wr_en_s  = in_range_s;
        result_s = {RESP_WRITE_TAG, shreg_in_r[15:0]};
      end
      CMD_READ: result_s = {16'h0000, rd_s};
      default: begin
        if (shreg_in_r[31:24] == CLEAR_BYTE) conv_next_s = 16'h0000;
        else                                 conv_next_s = conv_count_r;
      end
    endcase
  end

  // Shift registers, result pipeline and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_in_r    <= 32'h0000_0000;
      shreg_out_r   <= 32'h0000_0000;
      pipe0_r       <= 32'h0000_0000;
      pipe1_r       <= 32'h0000_0000;
      cmd_word_r    <= 32'h0000_0000;
      bitcnt_r      <= 6'd0;
      channel_r     <= 6'd0;
      conv_count_r  <= 16'h0000;
      miso_r        <= 1'b0;
      cmd_valid_r   <= 1'b0;
      frame_error_r <= 1'b0;
    end else begin
      cmd_valid_r   <= exec_s;
      frame_error_r <= ferr_s;
      if (start_s) begin
        shreg_in_r  <= 32'h0000_0000;
        shreg_out_r <= pipe1_r;
        miso_r      <= pipe1_r[31];
        bitcnt_r    <= 6'd0;
      end else begin
        if (sample_s) begin
          shreg_in_r <= {shreg_in_r[30:0], mosi_s};
          if (bitcnt_r != BITCNT_SAT) bitcnt_r <= bitcnt_r + 6'd1;
        end
        if (advance_s) begin
          shreg_out_r <= {shreg_out_r[30:0], 1'b0};
          miso_r      <= shreg_out_r[30];
        end
      end
      if (exec_s) begin
        cmd_word_r   <= shreg_in_r;
        pipe1_r      <= pipe0_r;
        pipe0_r      <= result_s;
        conv_count_r <= conv_next_s;
        if (is_convert_s) channel_r <= ch_s;
      end
    end
  end

  // Register file: cleared on reset, written only by in-range WRITE commands
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_r[i] <= 16'h0000;
    end else if (exec_s && wr_en_s) begin
      regs_r[addr_s[AW-1:0]] <= shreg_in_r[15:0];
    end
  end

  assign MISO        = miso_r;
  assign cmd_valid   = cmd_valid_r;
  assign cmd_word    = cmd_word_r;
  assign channel_out = channel_r;
  assign frame_error = frame_error_r;

endmodule

// File: tb/tb_rhs_spi_responder.sv
// Directed bench for rhs_spi_responder: two lanes (seed 0 and seed 16) share the
// SPI bus and are checked against a frame-level behavioural model.
module tb_rhs_spi_responder;

  logic clk, rst, sclk, cs, mosi;
  logic miso_a, cmd_valid_a, frame_error_a;
  logic miso_b, cmd_valid_b, frame_error_b;
  logic [31:0] cmd_word_a, cmd_word_b;
  logic [5:0]  channel_out_a, channel_out_b;

  rhs_spi_responder #(.STARTING_SEED(0), .SYNC_STAGES(2), .REG_COUNT(64)) dut_a (
    .clk(clk), .rst(rst), .SCLK(sclk), .CS(cs), .MOSI(mosi), .MISO(miso_a),
    .cmd_valid(cmd_valid_a), .cmd_word(cmd_word_a), .channel_out(channel_out_a),
    .frame_error(frame_error_a)
  );

  rhs_spi_responder #(.STARTING_SEED(16), .SYNC_STAGES(2), .REG_COUNT(64)) dut_b (
    .clk(clk), .rst(rst), .SCLK(sclk), .CS(cs), .MOSI(mosi), .MISO(miso_b),
    .cmd_valid(cmd_valid_b), .cmd_word(cmd_word_b), .channel_out(channel_out_b),
    .frame_error(frame_error_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] word; logic [5:0] ch; } exp_t;

  int n_chk, n_err, n_valid, n_ferr, exp_ferr;
  exp_t exp_q[$];
  logic [31:0] qa[$], qb[$], cap_a[$], cap_b[$];
  logic [15:0] m_regs [0:255];
  logic [15:0] m_rom [251:255];
  int m_conv;
  logic [5:0] m_ch, held_ch;
  logic [31:0] held_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    qa = '{32'h0, 32'h0};
    qb = '{32'h0, 32'h0};
    for (int i = 0; i < 256; i++) m_regs[i] = 16'h0;
    m_conv = 0; m_ch = 6'd0; held_ch = 6'd0; held_word = 32'h0;
    exp_q.delete(); cap_a.delete(); cap_b.delete();
  endtask

  // Result a command produces, for seed 0 (ra) and seed 16 (rb)
  task automatic model_frame(input logic [31:0] c, output logic [31:0] ra, output logic [31:0] rb);
    int ch, a;
    ch = int'(c[21:16]);
    a  = int'(c[23:16]);
    ra = 32'h0; rb = 32'h0;
    if (c[31:30] == 2'b00) begin
      m_ch = c[21:16];
      if (ch < 16) begin
        ra = 32'((ch + m_conv) % 65536);
        rb = 32'((16 + ch + m_conv) % 65536);
      end
      m_conv = (m_conv + 1) % 65536;
    end else if (c[31:30] == 2'b01) begin
      if (c[31:24] == 8'h6A) m_conv = 0;
    end else if (c[31:30] == 2'b10) begin
      if (a < 64) m_regs[a] = c[15:0];
      ra = {16'hFFFF, c[15:0]}; rb = ra;
    end else begin
      if (a < 64)        ra = {16'h0, m_regs[a]};
      else if (a >= 251) ra = {16'h0, m_rom[a]};
      else               ra = 32'h0;
      rb = ra;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cmd_valid_a) begin
          n_valid++;
          if (exp_q.size() == 0) begin
            check("unexpected_cmd_valid", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            held_word = e.word;
            held_ch = e.ch;
          end
        end
        if (frame_error_a) n_ferr++;
        check("cmd_word", cmd_word_a, held_word);
        check("channel_out", {26'd0, channel_out_a}, {26'd0, held_ch});
        check("lane_b_cmd_valid", {31'd0, cmd_valid_b}, {31'd0, cmd_valid_a});
        check("lane_b_frame_error", {31'd0, frame_error_b}, {31'd0, frame_error_a});
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_miso", {31'd0, miso_a}, 32'd0);
    check("reset_cmd_valid", {31'd0, cmd_valid_a}, 32'd0);
    check("reset_frame_error", {31'd0, frame_error_a}, 32'd0);
  endtask

  // One CS-low window of nbits SCLK periods; rst_at >= 0 pulses rst before that bit
  task automatic spi_frame(input logic [31:0] w, input int nbits, input int rst_at);
    logic [31:0] ca, cb, ea, eb, ra, rb;
    exp_t e;
    ca = 32'h0; cb = 32'h0;
    ea = qa[0]; eb = qb[0];
    if (rst_at < 0) begin
      if (nbits == 32) begin
        model_frame(w, ra, rb);
        ea = qa.pop_front(); qa.push_back(ra);
        eb = qb.pop_front(); qb.push_back(rb);
        e.word = w; e.ch = m_ch;
        exp_q.push_back(e);
      end else begin
        exp_ferr++;
      end
    end
    cs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 32) ? w[31-i] : 1'b0;
      if (i == rst_at) begin
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
      repeat (6) @(negedge clk);
      if (i < 32) begin
        ca = {ca[30:0], miso_a};
        cb = {cb[30:0], miso_b};
      end
      sclk = 1'b1;
      repeat (6) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    cs = 1'b1;
    repeat (12) @(negedge clk);
    if (rst_at < 0) begin
      if (nbits < 32) begin
        ea = ea >> (32 - nbits);
        eb = eb >> (32 - nbits);
      end
      check("miso_word_a", ca, ea);
      check("miso_word_b", cb, eb);
      cap_a.push_back(ca);
      cap_b.push_back(cb);
    end else begin
      check("miso_after_rst", {31'd0, miso_a}, 32'd0);
    end
    check("cmd_valid_pending", 32'(exp_q.size()), 32'd0);
    check("frame_error_count", n_ferr, exp_ferr);
  endtask

  int base_v, base_f;

  initial begin
    m_rom = '{16'h0049, 16'h004E, 16'h0054, 16'h0041, 16'h0020};
    n_chk = 0; n_err = 0; n_valid = 0; n_ferr = 0; exp_ferr = 0;
    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    model_reset();
    fork
      monitor();
    join_none
    do_reset();
    check("reset_cmd_word", cmd_word_a, 32'h0);
    check("reset_channel", {26'd0, channel_out_a}, 32'd0);

    // Write/read round trip through the two-deep pipeline
    base_v = n_valid;
    spi_frame(32'h8005_BEEF, 32, -1);
    spi_frame(32'hC005_0000, 32, -1);
    spi_frame(32'h0000_0000, 32, -1);
    spi_frame(32'h0000_0000, 32, -1);
    check("s1_word3", cap_a[2], 32'hFFFF_BEEF);
    check("s1_word4", cap_a[3], 32'h0000_BEEF);
    check("s1_valid_pulses", n_valid - base_v, 32'd4);

    // Seeded CONVERT and CLEAR
    do_reset();
    for (int k = 0; k < 3; k++) spi_frame(32'h0003_0000, 32, -1);
    spi_frame(32'h6A00_0000, 32, -1);
    for (int k = 0; k < 3; k++) spi_frame(32'h0000_0000, 32, -1);
    check("s2_b_word3", cap_b[2], 32'h0000_0013);
    check("s2_b_word4", cap_b[3], 32'h0000_0014);
    check("s2_b_word7", cap_b[6], 32'h0000_0010);
    check("s2_a_word3", cap_a[2], 32'h0000_0003);

    // Identity ROM, out-of-range write
    do_reset();
    for (int a = 251; a <= 255; a++) spi_frame({8'hC0, 8'(a), 16'h0000}, 32, -1);
    spi_frame(32'h0000_0000, 32, -1);
    spi_frame(32'h0000_0000, 32, -1);
    spi_frame(32'h80C8_1234, 32, -1);
    spi_frame(32'hC0C8_0000, 32, -1);
    spi_frame(32'h0000_0000, 32, -1);
    spi_frame(32'h0000_0000, 32, -1);
    check("s3_rom251", cap_a[2], 32'h0000_0049);
    check("s3_rom252", cap_a[3], 32'h0000_004E);
    check("s3_rom253", cap_a[4], 32'h0000_0054);
    check("s3_rom254", cap_a[5], 32'h0000_0041);
    check("s3_rom255", cap_a[6], 32'h0000_0020);
    check("s3_write200_resp", cap_a[9], 32'hFFFF_1234);
    check("s3_read200", cap_a[10], 32'h0000_0000);

    // Short and long frames leave the pipeline untouched
    base_v = n_valid; base_f = n_ferr;
    spi_frame(32'hC005_0000, 20, -1);
    spi_frame(32'hC005_0000, 40, -1);
    check("s4_no_cmd_valid", n_valid - base_v, 32'd0);
    check("s4_frame_errors", n_ferr - base_f, 32'd2);
    spi_frame(32'h0000_0000, 32, -1);
    check("s4_pre_error_result", cap_a[cap_a.size()-1], 32'h0000_0002);

    // Reset mid-frame, then normal operation
    do_reset();
    spi_frame(32'h8001_5555, 32, 17);
    spi_frame(32'hC001_0000, 32, -1);
    spi_frame(32'h0000_0000, 32, -1);
    spi_frame(32'h0000_0000, 32, -1);
    check("s5_reg1_still_zero", cap_a[2], 32'h0000_0000);

    // Out-of-range CONVERT channel
    do_reset();
    spi_frame(32'h0014_0000, 32, -1);
    check("s6_channel20", {26'd0, channel_out_a}, 32'd20);
    spi_frame(32'h0000_0000, 32, -1);
    spi_frame(32'h0000_0000, 32, -1);
    spi_frame(32'h0000_0000, 32, -1);
    check("s6_ch20_sample", cap_a[2], 32'h0000_0000);
    check("s6_next_sample_a", cap_a[3], 32'h0000_0001);
    check("s6_next_sample_b", cap_b[3], 32'h0000_0011);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
